// File: rtl/comp_result_accum.sv
// comp_result_accum
// Collects comparator results (agb/alb/aeb flags plus 4-bit difference) over a
// window of WIN_LEN accepted samples. At the end of the window it presents the
// per-flag counts, a majority verdict and a sticky error flag on a valid/ready
// port.
// Optional feature: define COMP_ACC_MAXDIFF_EN to track the largest diff seen
// on agb samples. Without it, max_diff is tied to zero and no register is built.
module comp_result_accum #(
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             agb,
  input  logic             alb,
  input  logic             aeb,
  input  logic [3:0]       diff,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [1:0]       verdict,
  output logic             err,
  output logic [3:0]       max_diff
);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO     = '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] smp_cnt;
  logic             take;
  logic             one_hot;
  logic             last;
  logic             open_win;
  logic [CNT_W-1:0] gt_nxt, lt_nxt, eq_nxt;

  // Majority rule: ties, including the all-equal case, give 00.
  function automatic logic [1:0] verdict_f(input logic [CNT_W-1:0] g,
                                           input logic [CNT_W-1:0] l);
    if (g > l)      verdict_f = 2'b01;
    else if (l > g) verdict_f = 2'b10;
    else            verdict_f = 2'b00;
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == REPORT);
  assign busy      = (state != IDLE);

  assign take     = in_valid && in_ready;
  assign one_hot  = ({agb, alb, aeb} == 3'b100) || ({agb, alb, aeb} == 3'b010) ||
                    ({agb, alb, aeb} == 3'b001);
  assign last     = take && (smp_cnt == LAST_IDX);
  assign open_win = (state == IDLE) && start;

  // Post-increment counts, so the verdict can be taken on the closing edge.
  assign gt_nxt = gt_cnt + ((take && one_hot && agb) ? ONE : ZERO);
  assign lt_nxt = lt_cnt + ((take && one_hot && alb) ? ONE : ZERO);
  assign eq_nxt = eq_cnt + ((take && one_hot && aeb) ? ONE : ZERO);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)     state_nxt = ACCUM;
      ACCUM:   if (last)      state_nxt = REPORT;
      REPORT:  if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Window counters, sticky error and verdict; results hold until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt <= '0;
      gt_cnt  <= '0;
      lt_cnt  <= '0;
      eq_cnt  <= '0;
      verdict <= 2'b00;
      err     <= 1'b0;
    end else if (open_win) begin
      smp_cnt <= '0;
      gt_cnt  <= '0;
      lt_cnt  <= '0;
      eq_cnt  <= '0;
      verdict <= 2'b00;
      err     <= 1'b0;
    end else if (take) begin
      smp_cnt <= smp_cnt + ONE;
      gt_cnt  <= gt_nxt;
      lt_cnt  <= lt_nxt;
      eq_cnt  <= eq_nxt;
      if (!one_hot) err     <= 1'b1;
      if (last)     verdict <= verdict_f(gt_nxt, lt_nxt);
    end
  end

`ifdef COMP_ACC_MAXDIFF_EN
  logic [3:0] max_q;

  // Running maximum of diff over clean agb samples in the current window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      max_q <= 4'd0;
    else if (open_win)
      max_q <= 4'd0;
    else if (take && one_hot && agb && (diff > max_q))
      max_q <= diff;
  end

  assign max_diff = max_q;
`else
  logic unused_diff;

  assign unused_diff = ^diff;
  assign max_diff    = 4'd0;
`endif

endmodule

// File: tb/tb_comp_result_accum.sv
// Bench for comp_result_accum: a window-level reference model (queue of
// accepted samples, summarised when the window fills) is compared every
// falling edge, plus literal expectations for each directed window.
module tb_comp_result_accum;

  localparam int WIN_LEN = 8;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [3:0] gt;
    logic [3:0] lt;
    logic [3:0] eq;
    logic [1:0] vd;
    logic       er;
    logic [3:0] mx;
  } sum_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       agb = 1'b0, alb = 1'b0, aeb = 1'b0;
  logic [3:0] diff = 4'd0;
  logic       busy;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] gt_cnt, lt_cnt, eq_cnt;
  logic [1:0] verdict;
  logic       err;
  logic [3:0] max_diff;

  int n_chk = 0;
  int n_fail = 0;

  comp_result_accum #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .agb(agb), .alb(alb), .aeb(aeb), .diff(diff),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .verdict(verdict),
    .err(err), .max_diff(max_diff)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Summary of a full window straight from the sample list.
  function automatic sum_t summarize(input logic [6:0] q[$]);
    sum_t s;
    s = '0;
    foreach (q[i]) begin
      if ($countones(q[i][6:4]) != 1) s.er = 1'b1;
      else if (q[i][6]) begin
        s.gt++;
`ifdef COMP_ACC_MAXDIFF_EN
        if (q[i][3:0] > s.mx) s.mx = q[i][3:0];
`endif
      end
      else if (q[i][5]) s.lt++;
      else s.eq++;
    end
    if (s.gt > s.lt)      s.vd = 2'b01;
    else if (s.lt > s.gt) s.vd = 2'b10;
    else                  s.vd = 2'b00;
    return s;
  endfunction

  // Reference model: phase 0 idle, 1 collecting, 2 reporting.
  int          ph;
  sum_t        exp_s;
  logic [6:0]  q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0;
      exp_s <= '0;
      q.delete();
    end else begin
      case (ph)
        0: if (start) begin
          q.delete();
          exp_s <= '0;
          ph <= 1;
        end
        1: if (in_valid) begin
          q.push_back({agb, alb, aeb, diff});
          if (q.size() == WIN_LEN) begin
            exp_s <= summarize(q);
            ph <= 2;
          end
        end
        default: if (out_ready) ph <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, ph == 1);
      chk("out_valid", out_valid, ph == 2);
      chk("busy", busy, ph != 0);
      if (ph != 1) begin
        chk("gt_cnt", gt_cnt, exp_s.gt);
        chk("lt_cnt", lt_cnt, exp_s.lt);
        chk("eq_cnt", eq_cnt, exp_s.eq);
        chk("verdict", verdict, exp_s.vd);
        chk("err", err, exp_s.er);
        chk("max_diff", max_diff, exp_s.mx);
      end
    end
  end

  logic [6:0] win [WIN_LEN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sample encoding {agb, alb, aeb, diff[3:0]}.
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        tick();
      end
      {agb, alb, aeb, diff} = win[i];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    {agb, alb, aeb, diff} = 7'h00;
  endtask

  task automatic chk_sum(input string tag, input logic [3:0] g, input logic [3:0] l,
                         input logic [3:0] e, input logic [1:0] v, input logic er);
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_gt"}, gt_cnt, g);
    chk({tag, "_lt"}, lt_cnt, l);
    chk({tag, "_eq"}, eq_cnt, e);
    chk({tag, "_verdict"}, verdict, v);
    chk({tag, "_err"}, err, er);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_gt", gt_cnt, 4'd0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a window.
    win = '{7'h41, 7'h22, 7'h43, 7'h10, 7'h44, 7'h25, 7'h46, 7'h47};
    pulse_start();
    feed(3, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_gt", gt_cnt, 4'd0);
    chk("midrst_lt", lt_cnt, 4'd0);
    chk("midrst_max", max_diff, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 5 agb, 2 alb, 1 aeb, back to back.
    pulse_start();
    feed(WIN_LEN, 1'b0);
    chk_sum("w1", 4'd5, 4'd2, 4'd1, 2'b01, 1'b0);
    tick();
    chk("w1_idle", busy, 1'b0);

    // 3 agb, 3 alb, 2 aeb with gaps.
    win = '{7'h40, 7'h20, 7'h41, 7'h21, 7'h10, 7'h42, 7'h22, 7'h11};
    pulse_start();
    feed(WIN_LEN, 1'b1);
    chk_sum("w2", 4'd3, 4'd3, 4'd2, 2'b00, 1'b0);
    tick();

    // Two malformed samples plus 6 alb.
    win = '{7'h60, 7'h00, 7'h20, 7'h21, 7'h22, 7'h23, 7'h24, 7'h25};
    pulse_start();
    feed(WIN_LEN, 1'b0);
    chk_sum("w3", 4'd0, 4'd6, 4'd0, 2'b10, 1'b1);
    tick();

    // Downstream stall with start pulsed during REPORT and at the handshake.
    win = '{7'h41, 7'h22, 7'h43, 7'h10, 7'h44, 7'h25, 7'h46, 7'h47};
    out_ready = 1'b0;
    pulse_start();
    feed(WIN_LEN, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_gt", gt_cnt, 4'd5);
      start = (i == 4);
      tick();
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("stall_idle", busy, 1'b0);
    chk("stall_held_gt", gt_cnt, 4'd5);
    tick();
    chk("stall_start_ignored", busy, 1'b0);

    // max_diff: agb diffs 3, 9, 5; alb diff 15.
    win = '{7'h43, 7'h49, 7'h45, 7'h2F, 7'h10, 7'h11, 7'h12, 7'h13};
    pulse_start();
    feed(WIN_LEN, 1'b0);
    chk_sum("w5", 4'd3, 4'd1, 4'd4, 2'b01, 1'b0);
`ifdef COMP_ACC_MAXDIFF_EN
    chk("w5_max", max_diff, 4'd9);
`else
    chk("w5_max", max_diff, 4'd0);
`endif
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_result_accum.md
Name: comp_result_accum

Overview:
- Downstream consumer of the 4-bit subtract-based magnitude comparator.
- Accepts one comparator result per handshake: greater/less/equal flags plus the 4-bit difference.
- Accumulates results over a fixed window of WIN_LEN samples, then presents per-window counts and a majority verdict on a valid/ready output port.
- Sits between the comparator and the control/reporting logic.

Parameters:
- WIN_LEN, 8, samples per window; legal range 1..(2^CNT_W - 1).
- CNT_W, 4, width of each count output.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; opens a new window (honoured in IDLE only).
- in_valid  input  1  upstream result valid.
- in_ready  output  1  block accepts a result this cycle.
- agb  input  1  comparator A>B flag.
- alb  input  1  comparator A<B flag.
- aeb  input  1  comparator A==B flag.
- diff  input  4  comparator difference A-B, modulo 16.
- busy  output  1  high in ACCUM or REPORT.
- out_valid  output  1  window summary valid.
- out_ready  input  1  downstream accepts the summary.
- gt_cnt  output  CNT_W  count of agb samples in the window.
- lt_cnt  output  CNT_W  count of alb samples in the window.
- eq_cnt  output  CNT_W  count of aeb samples in the window.
- verdict  output  2  01 = A>B majority, 10 = A<B majority, 00 = tie.
- err  output  1  sticky; a sample without exactly one flag set was seen.
- max_diff  output  4  largest diff among agb samples (optional feature).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - All counts, verdict, err and max_diff clear to 0.
  - in_ready, out_valid and busy go low.
  - Reset mid-window discards the partial window; no summary is produced.
- FSM states: IDLE, ACCUM, REPORT.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> ACCUM next cycle; counts, err, max_diff and the sample counter clear on the same edge.
- ACCUM:
  - in_ready=1, combinationally equal to (state==ACCUM).
  - A sample is consumed when in_valid && in_ready.
  - Exactly one of agb/alb/aeb set: the matching count increments.
  - Zero or more than one flag set: no count increments, err sets, and the sample still counts toward the window.
  - When the WIN_LEN-th sample is consumed -> REPORT next cycle.
  - The verdict is registered on that same edge from the post-increment counts.
  - in_valid low: stall indefinitely, no timeout.
- REPORT:
  - out_valid=1, in_ready=0.
  - Counts, verdict, err and max_diff are held stable while out_valid && !out_ready.
  - On out_valid && out_ready -> IDLE. Outputs keep their values until the next start clears them.
- Verdict rule:
  - gt_cnt > lt_cnt -> 01.
  - lt_cnt > gt_cnt -> 10.
  - Otherwise -> 00.
  - eq_cnt does not affect the verdict.
- busy = (state != IDLE).
- start outside IDLE is ignored, including start coincident with the final sample or with the out handshake.
- Counts never wrap: the parameter range guarantees each count is at most WIN_LEN.
- Latency: out_valid rises exactly one cycle after the clock edge that consumes the last sample.
- Back-to-back windows: the earliest new start is the cycle after the out handshake; throughput is WIN_LEN + 2 cycles minimum.

Optional Feature:
- Macro: COMP_ACC_MAXDIFF_EN.
- Defined:
  - max_diff holds the unsigned maximum of diff over consumed samples with agb valid (exactly one flag set).
  - Cleared on start; updated on the same edge as the count.
  - Held through REPORT.
- Undefined:
  - max_diff tied to 4'd0.
  - No max register is synthesised.
  - The port remains present.

Test Plan:
- Reset during ACCUM after 3 samples -> all outputs 0, state IDLE; a new start and 8 fresh samples give counts of the new window only.
- start, then 8 samples: 5 agb, 2 alb, 1 aeb, in_valid held high -> out_valid one cycle after the 8th accept; gt=5, lt=2, eq=1, verdict=01, err=0.
- start, then 8 samples: 3 agb, 3 alb, 2 aeb, with in_valid toggled every other cycle -> same outputs regardless of gaps; verdict=00.
- One sample with agb=alb=1 and one with no flag, plus 6 alb -> lt=6, gt=0, eq=0, err=1, verdict=10; window still closes after 8 accepts.
- out_ready held low 10 cycles in REPORT, with start pulsed during it -> outputs stable and out_valid high throughout; start ignored; IDLE after out_ready=1.
- COMP_ACC_MAXDIFF_EN defined, agb samples with diff 3, 9, 5 and an alb sample with diff 15 -> max_diff=9. Undefined -> max_diff=0.
